osd_dii_egress_arbiter: RTL

- Packet-level round-robin arbiter that shares one DII egress channel between N DII sources, e.g. several debug modules feeding the host interface egress path.
- A grant is held from the first flit of a packet through its last flit, so packets are never interleaved.
- Sits directly upstream of the host interface module's dii_in port.
- Adds one registered arbitration cycle per packet and exposes grant/status information for debug.

---
 rtl/osd_dii_egress_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/osd_dii_egress_arbiter.sv
// Packet-level round-robin arbiter sharing one DII egress channel between N sources.
// A grant is held from first flit through last flit; one IDLE arbitration cycle per packet.
module osd_dii_egress_arbiter #(
  parameter int N    = 4,
  parameter int IDXW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*16-1:0]      in_data,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0]         in_first,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic [15:0]          out_data,
  output logic                 out_valid,
  output logic                 out_first,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic [IDXW-1:0]      grant_idx,
  output logic                 busy,
  output logic [15:0]          pkt_count,
  output logic                 err_proto
);

  localparam int unsigned NU = N;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] winner;
  logic            any_req;
  logic            first_done;
  logic [N-1:0]    req;
  logic            xfer;

  assign req  = in_valid & in_first;
  assign busy = (state == ACTIVE);
  assign xfer = out_valid & out_ready;

  // Scan ptr+1 .. ptr+N modulo N; the first set request wins, so the
  // port that just finished (ptr) is considered last.
  always_comb begin
    int unsigned idx;
    any_req = 1'b0;
    winner  = ptr;
    for (int unsigned k = 1; k <= NU; k++) begin
      idx = (32'(ptr) + k) % NU;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = IDXW'(idx);
      end
    end
  end

  always_comb begin
    out_data  = '0;
    out_valid = 1'b0;
    out_first = 1'b0;
    out_last  = 1'b0;
    in_ready  = '0;
    if (state == ACTIVE) begin
      out_data            = in_data[16*grant_idx +: 16];
      out_valid           = in_valid[grant_idx];
      out_first           = in_first[grant_idx];
      out_last            = in_last[grant_idx];
      in_ready[grant_idx] = out_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_idx  <= '0;
      ptr        <= IDXW'(N - 1);
      pkt_count  <= '0;
      err_proto  <= 1'b0;
      first_done <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|(in_valid & ~in_first)) err_proto <= 1'b1;
          if (any_req) begin
            grant_idx  <= winner;
            state      <= ACTIVE;
            first_done <= 1'b0;
          end
        end
        ACTIVE: begin
          if (xfer) begin
            first_done <= 1'b1;
            // A second first-flit inside one grant is still forwarded, only flagged.
            if (out_first && first_done) err_proto <= 1'b1;
            if (out_last) begin
              state     <= IDLE;
              ptr       <= grant_idx;
              pkt_count <= pkt_count + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
